// File: rtl/ps2_device_if.sv
// Byte-level bus between the PS/2 device endpoint and its user logic.
// tx: a byte moves on any clock edge where tx_valid & tx_ready; rx: rx_valid is a one-cycle pulse qualifying rx_data/rx_err.
interface ps2_device_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, rx_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, rx_err
    );
endinterface

// File: rtl/ps2_device.sv
// Device-side PS/2 endpoint: sources the PS/2 clock, sends bytes to the host,
// receives host command bytes and acknowledges them. Lines are open-drain via active-low enables.
module ps2_device #(
    parameter int CLK_HALF    = 2500,
    parameter int INHIBIT_CYC = 2500,
    parameter int GAP_CYC     = 5000
) (
    input  logic         clk,
    input  logic         rst,
    output logic         ps2_clk_en_o_,
    output logic         ps2_data_en_o_,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    ps2_device_if.slave  bus,
    output logic         busy,
    output logic [2:0]   dbg_state
);

    localparam int CNT_M1  = (CLK_HALF > INHIBIT_CYC) ? CLK_HALF : INHIBIT_CYC;
    localparam int CNT_MAX = (CNT_M1 > GAP_CYC) ? CNT_M1 : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LAST   = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] INH_LAST    = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] SYNC_SETTLE = CW'(2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TX_CHK = 3'd1,
        S_TX     = 3'd2,
        S_RX     = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_slot;
    logic          r_low;
    logic          r_clk_en;
    logic          r_data_en;
    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_dat_s1;
    logic          r_dat_s2;
    logic [7:0]    r_tx_byte;
    logic          r_pend;
    logic          r_tx_ready;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_rx_err;

    logic          w_clk;
    logic          w_dat;
    logic          w_rts;
    logic          w_accept;
    logic          w_half_end;
    logic          w_inhibit;
    logic [3:0]    w_slot_nx;
    logic [15:0]   w_frame;

    assign w_clk      = r_clk_s2;
    assign w_dat      = r_dat_s2;
    assign w_rts      = w_clk & ~w_dat;
    assign w_accept   = bus.tx_valid & r_tx_ready;
    assign w_half_end = (r_cnt == HALF_LAST);
    assign w_slot_nx  = r_slot + 4'd1;
    assign w_frame    = {5'b0_0000, 1'b1, ~^r_tx_byte, r_tx_byte, 1'b0};
    // Right after the device releases the clock the synced value is still stale
    // for two cycles, so host inhibit is only trusted once the synchronisers settle.
    assign w_inhibit  = ~r_low & (r_cnt >= SYNC_SETTLE) & ~w_clk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_slot     <= 4'd0;
            r_low      <= 1'b0;
            r_clk_en   <= 1'b1;
            r_data_en  <= 1'b1;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_tx_byte  <= 8'h00;
            r_pend     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_shift    <= 8'h00;
            r_par      <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk_i;
            r_clk_s2   <= r_clk_s1;
            r_dat_s1   <= ps2_data_i;
            r_dat_s2   <= r_dat_s1;
            r_rx_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_rts) begin
                        r_state   <= S_RX;
                        r_slot    <= 4'd1;
                        r_low     <= 1'b0;
                        r_clk_en  <= 1'b1;
                        r_data_en <= 1'b1;
                    end else if (w_clk && r_pend) begin
                        r_state <= S_TX_CHK;
                    end
                end

                S_TX_CHK: begin
                    if (w_rts) begin
                        r_state   <= S_RX;
                        r_cnt     <= '0;
                        r_slot    <= 4'd1;
                        r_low     <= 1'b0;
                        r_clk_en  <= 1'b1;
                        r_data_en <= 1'b1;
                    end else if (!w_clk) begin
                        r_cnt <= '0;
                    end else if (r_cnt == INH_LAST) begin
                        r_state   <= S_TX;
                        r_cnt     <= '0;
                        r_slot    <= 4'd0;
                        r_low     <= 1'b0;
                        r_clk_en  <= 1'b1;
                        r_data_en <= w_frame[0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_TX: begin
                    // The stop slot is past the point of no return: a late inhibit is ignored.
                    if (w_inhibit && (r_slot <= 4'd9)) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_low     <= 1'b0;
                        r_clk_en  <= 1'b1;
                        r_data_en <= 1'b1;
                    end else if (w_half_end) begin
                        r_cnt <= '0;
                        if (!r_low) begin
                            r_low    <= 1'b1;
                            r_clk_en <= 1'b0;
                        end else if (r_slot == 4'd10) begin
                            r_state   <= S_GAP;
                            r_low     <= 1'b0;
                            r_clk_en  <= 1'b1;
                            r_data_en <= 1'b1;
                            r_pend    <= 1'b0;
                        end else begin
                            r_low     <= 1'b0;
                            r_clk_en  <= 1'b1;
                            r_slot    <= w_slot_nx;
                            r_data_en <= w_frame[w_slot_nx];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RX: begin
                    if (w_inhibit) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_low     <= 1'b0;
                        r_clk_en  <= 1'b1;
                        r_data_en <= 1'b1;
                    end else if (w_half_end) begin
                        r_cnt <= '0;
                        if (!r_low) begin
                            r_low    <= 1'b1;
                            r_clk_en <= 1'b0;
                            if (r_slot <= 4'd8) begin
                                r_shift <= {w_dat, r_shift[7:1]};
                            end else if (r_slot == 4'd9) begin
                                r_par <= w_dat;
                            end else if ((r_slot == 4'd10) && !w_dat) begin
                                // Framing error: stay silent and let the host time out.
                                r_state  <= S_GAP;
                                r_low    <= 1'b0;
                                r_clk_en <= 1'b1;
                            end
                        end else if (r_slot == 4'd11) begin
                            r_state    <= S_GAP;
                            r_low      <= 1'b0;
                            r_clk_en   <= 1'b1;
                            r_data_en  <= 1'b1;
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= r_shift;
                            r_rx_err   <= ~(^{r_shift, r_par});
                        end else begin
                            r_low    <= 1'b0;
                            r_clk_en <= 1'b1;
                            r_slot   <= w_slot_nx;
                            if (r_slot == 4'd10) begin
                                r_data_en <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        if (!r_pend) begin
                            r_tx_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_clk_en  <= 1'b1;
                    r_data_en <= 1'b1;
                end
            endcase

            // tx_ready is only high with nothing pending, so this never collides with the frame logic.
            if (w_accept) begin
                r_pend     <= 1'b1;
                r_tx_byte  <= bus.tx_data;
                r_tx_ready <= 1'b0;
            end
        end
    end

    assign ps2_clk_en_o_  = r_clk_en;
    assign ps2_data_en_o_ = r_data_en;
    assign bus.tx_ready   = r_tx_ready;
    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.rx_err     = r_rx_err;
    assign busy           = (r_state != S_IDLE);
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_ps2_device.sv
// Directed bench for ps2_device: plays a PS/2 host against the device on
// resolved open-drain lines and checks frames, acks and handshake timing.
module tb_ps2_device;

    localparam int CLK_HALF    = 4;
    localparam int INHIBIT_CYC = 8;
    localparam int GAP_CYC     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       host_clk = 1'b1;
    logic       host_data = 1'b1;
    logic       ps2_clk_en_o_;
    logic       ps2_data_en_o_;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       busy;
    logic [2:0] dbg_state;
    int         n_cmp = 0;
    int         n_err = 0;

    ps2_device_if bus_if ();

    assign ps2_clk_i  = ps2_clk_en_o_ & host_clk;
    assign ps2_data_i = ps2_data_en_o_ & host_data;

    ps2_device #(
        .CLK_HALF    (CLK_HALF),
        .INHIBIT_CYC (INHIBIT_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_clk_en_o_  (ps2_clk_en_o_),
        .ps2_data_en_o_ (ps2_data_en_o_),
        .ps2_clk_i      (ps2_clk_i),
        .ps2_data_i     (ps2_data_i),
        .bus            (bus_if.slave),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus_if.tx_ready;
            1:       return !busy;
            2:       return bus_if.rx_valid;
            3:       return ps2_clk_i;
            4:       return busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int limit, output int cyc);
        cyc = 0;
        while (!sig(sel) && (cyc < limit)) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_reached"}, 32'(sig(sel)), 32'd1);
    endtask

    task automatic wait_fall(input string tag, output logic smp, output int cyc);
        logic prev;
        bit   seen;
        prev = ps2_clk_i;
        seen = 1'b0;
        smp  = 1'b0;
        cyc  = 0;
        while (!seen && (cyc < 3000)) begin
            @(negedge clk);
            cyc++;
            if (prev && !ps2_clk_i) begin
                seen = 1'b1;
                smp  = ps2_data_i;
            end
            prev = ps2_clk_i;
        end
        if (!seen) check({tag, "_fall_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic capture_frame(input string tag, output logic [10:0] f, output int first_cyc);
        logic s;
        int   c;
        f = '0;
        first_cyc = 0;
        for (int k = 0; k < 11; k++) begin
            wait_fall(tag, s, c);
            f[k] = s;
            if (k == 0) first_cyc = c;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int c;
        wait_for("send_ready", 0, 200, c);
        bus_if.tx_data  = b;
        bus_if.tx_valid = 1'b1;
        tick();
        bus_if.tx_valid = 1'b0;
        check("tx_ready_drop", 32'(bus_if.tx_ready), 32'd0);
    endtask

    task automatic host_rts(input bit with_tx, input logic [7:0] txb);
        int c;
        host_clk = 1'b0;
        repeat (4) tick();
        host_data = 1'b0;
        repeat (2) tick();
        host_clk = 1'b1;
        if (with_tx) begin
            repeat (2) tick();
            bus_if.tx_data  = txb;
            bus_if.tx_valid = 1'b1;
            tick();
            bus_if.tx_valid = 1'b0;
            check("rts_tx_ready_drop", 32'(bus_if.tx_ready), 32'd0);
            check("rts_busy", 32'(busy), 32'd1);
        end else begin
            wait_for("rts_busy", 4, 20, c);
        end
    endtask

    task automatic host_bits(input string tag, input logic [7:0] d, input logic p,
                             input logic s, input logic exp_err);
        logic [9:0] bits;
        logic       smp;
        int         c;
        bits = {s, p, d};
        host_data = bits[0];
        for (int k = 1; k < 10; k++) begin
            wait_fall(tag, smp, c);
            host_data = bits[k];
        end
        wait_fall(tag, smp, c);
        host_data = 1'b1;
        wait_fall(tag, smp, c);
        check({tag, "_ack_line"}, 32'(smp), 32'd0);
        check({tag, "_ack_drive"}, 32'(ps2_data_en_o_), 32'd0);
        wait_for({tag, "_rx_valid"}, 2, 20, c);
        check({tag, "_rx_data"}, 32'(bus_if.rx_data), 32'(d));
        check({tag, "_rx_err"}, 32'(bus_if.rx_err), 32'(exp_err));
        tick();
        check({tag, "_rx_valid_pulse"}, 32'(bus_if.rx_valid), 32'd0);
    endtask

    initial begin
        logic       s;
        logic [10:0] f;
        int         c;

        bus_if.tx_data  = 8'h00;
        bus_if.tx_valid = 1'b0;
        rst = 1'b0;
        repeat (5) tick();
        check("rst_clk_en", 32'(ps2_clk_en_o_), 32'd1);
        check("rst_data_en", 32'(ps2_data_en_o_), 32'd1);
        check("rst_tx_ready", 32'(bus_if.tx_ready), 32'd1);
        check("rst_rx_data", 32'(bus_if.rx_data), 32'd0);
        check("rst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
        check("rst_rx_err", 32'(bus_if.rx_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (3) tick();

        // Device-to-host byte 0x1C: frame bits 0,0,0,1,1,1,0,0,0,0,1.
        send_byte(8'h1C);
        capture_frame("t1", f, c);
        check("t1_frame", 32'(f), 32'h438);
        check("t1_ready_low", 32'(bus_if.tx_ready), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        wait_for("t1_ready", 0, 100, c);
        check("t1_ready_delay", 32'(c), 32'd20);
        check("t1_idle", 32'(busy), 32'd0);

        // Host command 0xFF with correct parity.
        host_rts(1'b0, 8'h00);
        host_bits("t2", 8'hFF, 1'b1, 1'b1, 1'b0);
        wait_for("t2_idle", 1, 100, c);

        // Host command 0xED with wrong parity: still acked, flagged.
        host_rts(1'b0, 8'h00);
        host_bits("t3", 8'hED, 1'b0, 1'b1, 1'b1);
        wait_for("t3_idle", 1, 100, c);

        // 0xAA aborted by host inhibit in slot 5, then resent whole.
        send_byte(8'hAA);
        repeat (5) wait_fall("t4_pre", s, c);
        wait_for("t4_rise", 3, 20, c);
        tick();
        host_clk = 1'b0;
        repeat (3) tick();
        check("t4_clk_rel", 32'(ps2_clk_en_o_), 32'd1);
        check("t4_data_rel", 32'(ps2_data_en_o_), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_ready", 32'(bus_if.tx_ready), 32'd0);
        repeat (20) tick();
        check("t4_hold_ready", 32'(bus_if.tx_ready), 32'd0);
        check("t4_hold_busy", 32'(busy), 32'd0);
        host_clk = 1'b1;
        capture_frame("t4", f, c);
        check("t4_frame", 32'(f), 32'h754);
        check("t4_restart_window", 32'((c >= 12) && (c <= 18)), 32'd1);
        wait_for("t4_ready_back", 0, 100, c);

        // Byte 0x55 offered in the same cycle as host RTS: RX first, then TX.
        host_rts(1'b1, 8'h55);
        host_bits("t5", 8'h12, 1'b1, 1'b1, 1'b0);
        capture_frame("t5", f, c);
        check("t5_frame", 32'(f), 32'h6AA);
        wait_for("t5_ready", 0, 100, c);

        // Asynchronous reset in the low phase of TX slot 4, then a clean frame.
        send_byte(8'h81);
        repeat (5) wait_fall("t6_pre", s, c);
        tick();
        check("t6_pre_clk_low", 32'(ps2_clk_en_o_), 32'd0);
        rst = 1'b0;
        #1;
        check("t6_clk_en", 32'(ps2_clk_en_o_), 32'd1);
        check("t6_data_en", 32'(ps2_data_en_o_), 32'd1);
        check("t6_tx_ready", 32'(bus_if.tx_ready), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rx_valid", 32'(bus_if.rx_valid), 32'd0);
        check("t6_rx_data", 32'(bus_if.rx_data), 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        send_byte(8'h3F);
        capture_frame("t6", f, c);
        check("t6_frame", 32'(f), 32'h67E);
        wait_for("t6_ready", 0, 100, c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_device.md
Name: ps2_device

Overview:
- Device-side PS/2 endpoint, i.e. a keyboard/mouse emulator. It is the far end of the host-side PS/2 controller.
- Sources the PS/2 clock and sends scan-code/mouse bytes to the host.
- Accepts host-to-device command bytes and sends the acknowledge.
- Used for loopback and self-test builds and for simulation benches. Drives the same open-drain IO buffers through active-low drive enables.

Parameters:
- CLK_HALF, 2500: system-clock cycles per PS/2 clock half-period (50 MHz gives 10 kHz).
- INHIBIT_CYC, 2500: cycles the PS/2 clock line must read high continuously before a device-to-host frame may start.
- GAP_CYC, 5000: idle cycles enforced after every frame.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous assert, active-low
- ps2_clk_en_o_  out  1  0 = drive PS/2 clock low, 1 = release
- ps2_data_en_o_  out  1  0 = drive PS/2 data low, 1 = release
- ps2_clk_i  in  1  resolved PS/2 clock line
- ps2_data_i  in  1  resolved PS/2 data line
- tx_data  in  8  byte to send to host
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  device can accept a byte
- rx_data  out  8  last host command byte
- rx_valid  out  1  one-cycle pulse, rx_data/rx_err valid
- rx_err  out  1  parity error on the received byte
- busy  out  1  frame in progress (not IDLE)

Behaviour:
- Reset (rst=0) values: ps2_clk_en_o_=1, ps2_data_en_o_=1, tx_ready=1, rx_data=0, rx_valid=0, rx_err=0, busy=0, state IDLE, pending byte cleared.
  - Reset mid-frame releases both lines immediately (asynchronously).
- Input sync: ps2_clk_i and ps2_data_i pass through 2-flop synchronisers. All decisions below use the synced values (2-cycle latency).
- TX handshake:
  - Byte accepted when tx_valid & tx_ready. It is latched and tx_ready drops the next cycle.
  - tx_ready returns to 1 one cycle after GAP completes following a successful TX frame.
- Bit timing: each bit slot is CLK_HALF cycles with the clock released (high), then CLK_HALF cycles with the clock driven low.
- States:
  - IDLE:
    - Synced clk=1 & synced data=0 (host request-to-send): go to RX. RX has priority over a pending TX byte.
    - Else if a byte is pending: go to TX_CHK.
    - Synced clk=0 (host inhibit): stay in IDLE.
  - TX_CHK: counts INHIBIT_CYC consecutive cycles of synced clk=1. Any low sample restarts the count. A host RTS seen here goes to RX and keeps the byte pending.
  - TX:
    - 11 slots: start 0, data[0..7] LSB first, odd parity, stop 1.
    - Device sets ps2_data_en_o_ at the start of each high phase (0 for bit 0, 1 for bit 1). The host samples on the falling edge.
    - Inhibit abort: if synced clk reads 0 during a high phase of slots 0-9, release both lines within 3 cycles. Go to IDLE with the byte still pending and tx_ready=0. The whole frame is retransmitted later.
    - A low clock during slot 10 is ignored; the frame counts as sent.
  - RX:
    - 10 clock slots. At the last cycle of each high phase, sample synced data: slots 1-8 are data LSB first, slot 9 is parity, slot 10 is stop.
    - Slot 11 (ACK): device drives data low for the whole high and low phase of slot 11, then releases both lines.
    - Stop bit read as 0: no ACK is driven, no rx_valid pulse, go to GAP (host times out).
    - Host pulls clock low during RX: abort to IDLE with no rx_valid.
  - RX outputs: rx_valid pulses for one cycle at the end of slot 11. rx_data is updated and rx_err = (XOR of 8 data bits + parity) == 0. The ACK is sent even when rx_err=1.
  - GAP: both lines released for GAP_CYC cycles, then IDLE.
- busy=1 in every state except IDLE.
- Counters: the half-period counter is wide enough for max(CLK_HALF, INHIBIT_CYC, GAP_CYC). The slot counter is 4 bits and never wraps past 11.

Test Plan (CLK_HALF=4, INHIBIT_CYC=8, GAP_CYC=16):
1. tx_data=0x1C, tx_valid pulse, clk line idle high -> 11 falling edges with data sampled 0,0,0,1,1,1,0,0,0,0,1; tx_ready=0 during the frame, back to 1 after GAP.
2. Host RTS, then drives 0xFF LSB first with parity 1 and stop 1 -> device drives data low in slot 11; rx_valid one-cycle pulse; rx_data=0xFF; rx_err=0.
3. Host sends 0xED with parity 0 (wrong) -> ACK still driven; rx_valid pulse; rx_data=0xED; rx_err=1.
4. TX of 0xAA; host pulls clock low during slot 5 high phase -> both enables=1 within 3 cycles; tx_ready stays 0; after clock release plus 8 cycles, the full 0xAA frame restarts from the start bit.
5. tx_valid=1 (0x55) in the same cycle a host RTS is synced in IDLE -> RX frame completes first, then the 0x55 frame, with no byte loss.
6. rst=0 during TX slot 4 -> both enables go to 1 with no clk edge needed; tx_ready=1, busy=0, rx_valid=0; after rst=1 a new byte transmits normally.
